// File: rtl/switch_operand_capture.sv
// -----------------------------------------------------------------------------
// switch_operand_capture
//
// Input front end for the 2-bit magnitude-comparator demos. It takes two raw
// switch groups, runs each bit through a 2-FF synchroniser, and debounces each
// group as a whole. Downstream compare logic then sees clean, stable operands,
// together with a "both operands known" flag and a change strobe.
//
// Each group (A, B) has its own two-state FSM:
//   STABLE   : syncd == committed. A difference starts SETTLING with
//              candidate = syncd and the counter at 0.
//   SETTLING : a change of syncd restarts (new candidate, counter 0). When the
//              counter reaches DEBOUNCE_CYCLES-1 with syncd still equal to the
//              candidate, the candidate is committed and the FSM goes STABLE.
// Reset puts both groups in SETTLING with candidate 0, so a group whose
// switches are all released commits 0 shortly after reset.
//
// Optional build macro:
//   SW_ACTIVE_LOW_EN - pull-up switches (pressed = 0). The synchroniser
//                      resets to all ones and its output is inverted before
//                      the FSM, so the reset view is still 0.
//
// Parameters:
//   WIDTH           - bits per operand group
//   DEBOUNCE_CYCLES - cycles a group must hold its value before commit (>= 2)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sw_a_raw   in   raw switch pins, operand A (asynchronous to clk)
//   sw_b_raw   in   raw switch pins, operand B (asynchronous to clk)
//   a_out      out  committed debounced operand A
//   b_out      out  committed debounced operand B
//   valid      out  both groups have committed at least once since reset
//   upd        out  one-cycle strobe, same cycle as new operand values
//   busy       out  either group is SETTLING
//   dbg_state  out  per-group FSM state, bit g = group g in SETTLING (A=0, B=1)
//
// Handshake: there is none. valid is a level; upd is a one-cycle pulse that
// needs no acknowledge. a_out/b_out change only in the cycle upd is high,
// except for commits before valid rises, which are not strobed.
// -----------------------------------------------------------------------------
module switch_operand_capture #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_a_raw,
  input  logic [WIDTH-1:0] sw_b_raw,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic             upd,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef SW_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] SYNC_RST = '1;
`else
  localparam logic [WIDTH-1:0] SYNC_RST = '0;
`endif

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } grp_state_e;

  // Index 0 is group A, index 1 is group B.
  logic [1:0][WIDTH-1:0] raw_w;
  logic [1:0][WIDTH-1:0] meta_q;
  logic [1:0][WIDTH-1:0] sync_q;
  logic [1:0][WIDTH-1:0] syncd_w;

  grp_state_e            state_q [2];
  grp_state_e            state_d [2];
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0] cand_q, cand_d;
  logic [1:0][WIDTH-1:0] comm_q, comm_d;
  logic [1:0]            done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  upd_q, upd_d;

  assign raw_w[0] = sw_a_raw;
  assign raw_w[1] = sw_b_raw;

  // 2-FF synchroniser; only the second stage feeds the FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {2{SYNC_RST}};
      sync_q <= {2{SYNC_RST}};
    end else begin
      meta_q <= raw_w;
      sync_q <= meta_q;
    end
  end

`ifdef SW_ACTIVE_LOW_EN
  assign syncd_w = ~sync_q;
`else
  assign syncd_w = sync_q;
`endif

  // Per-group debounce FSMs plus the shared valid/upd logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    comm_d  = comm_q;
    done_d  = done_q;

    for (int g = 0; g < 2; g++) begin
      case (state_q[g])
        ST_STABLE: begin
          if (syncd_w[g] != comm_q[g]) begin
            state_d[g] = ST_SETTLING;
            cnt_d[g]   = '0;
            cand_d[g]  = syncd_w[g];
          end
        end
        ST_SETTLING: begin
          if (syncd_w[g] != cand_q[g]) begin
            cand_d[g] = syncd_w[g];
            cnt_d[g]  = '0;
          end else if (cnt_q[g] == CNT_LAST) begin
            // Counter stops here; it never wraps.
            comm_d[g]  = cand_q[g];
            done_d[g]  = 1'b1;
            state_d[g] = ST_STABLE;
          end else begin
            cnt_d[g] = cnt_q[g] + CNT_W'(1);
          end
        end
      endcase
    end

    // Both built from next-state values so valid and upd land in the same
    // cycle as the committed operands they describe.
    valid_d = done_d[0] & done_d[1];
    upd_d   = valid_d & (~valid_q | (comm_d != comm_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) state_q[g] <= ST_SETTLING;
      cnt_q   <= '0;
      cand_q  <= '0;
      comm_q  <= '0;
      done_q  <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) state_q[g] <= state_d[g];
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      comm_q  <= comm_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  assign a_out     = comm_q[0];
  assign b_out     = comm_q[1];
  assign valid     = valid_q;
  assign upd       = upd_q;
  assign dbg_state = {state_q[1] == ST_SETTLING, state_q[0] == ST_SETTLING};
  assign busy      = |dbg_state;

endmodule

// File: tb/tb_switch_operand_capture.sv
// -----------------------------------------------------------------------------
// Bench for switch_operand_capture (DEBOUNCE_CYCLES overridden to 4).
// The reference model describes each group as "the synchronised view is the
// raw input two edges late; while settling, a value is committed once it has
// been seen on D+1 consecutive sampled edges". Operands, valid, upd, busy and
// per-group settling are checked against it every cycle, and the directed
// scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_switch_operand_capture;

  localparam int W = 2;
  localparam int D = 4;

`ifdef SW_ACTIVE_LOW_EN
  localparam logic [W-1:0] INV = '1;
`else
  localparam logic [W-1:0] INV = '0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_a = '0 ^ INV;
  logic [W-1:0] sw_b = '0 ^ INV;
  logic [W-1:0] a_out, b_out;
  logic         valid, upd, busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  switch_operand_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_a_raw  (sw_a),
    .sw_b_raw  (sw_b),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid     (valid),
    .upd       (upd),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int upd_cnt  = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hist [2][$];  // raw values sampled at recent edges
  logic [W-1:0] m_run_val [2];
  int           m_run_len [2];
  logic [W-1:0] m_comm [2];
  bit           m_settling [2];
  bit           m_done [2];
  bit           m_valid, m_upd;

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_hist[g].delete();
      m_hist[g].push_back(INV);   // synchroniser reset contents
      m_hist[g].push_back(INV);
      m_run_val[g]  = '0;
      m_run_len[g]  = 1;          // reset counts as one sample of candidate 0
      m_comm[g]     = '0;
      m_settling[g] = 1'b1;
      m_done[g]     = 1'b0;
    end
    m_valid = 1'b0;
    m_upd   = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic [W-1:0] old_comm [2];
    bit           old_valid;
    old_valid = m_valid;
    for (int g = 0; g < 2; g++) begin
      old_comm[g] = m_comm[g];
      s = m_hist[g].pop_front() ^ INV;
      m_hist[g].push_back(g == 0 ? sw_a : sw_b);
      if (s == m_run_val[g]) m_run_len[g]++;
      else begin
        m_run_val[g] = s;
        m_run_len[g] = 1;
      end
      if (!m_settling[g]) begin
        if (s != m_comm[g]) m_settling[g] = 1'b1;
      end else if (m_run_len[g] >= D + 1) begin
        m_comm[g]     = m_run_val[g];
        m_done[g]     = 1'b1;
        m_settling[g] = 1'b0;
      end
    end
    m_valid = m_done[0] && m_done[1];
    m_upd   = m_valid && (!old_valid || m_comm[0] != old_comm[0] || m_comm[1] != old_comm[1]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check("a_out", a_out, m_comm[0]);
        check("b_out", b_out, m_comm[1]);
        check("valid", valid, m_valid);
        check("upd",   upd,   m_upd);
        check("busy",  busy,  m_settling[0] || m_settling[1]);
        check("dbg_state", dbg_state, {m_settling[1], m_settling[0]});
        if (upd)  upd_cnt++;
        if (busy) busy_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic set_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    sw_a = a ^ INV;
    sw_b = b ^ INV;
  endtask

  task automatic reset_capture(input string tag);
    int u0;
    set_ab(2'b10, 2'b01);
    tick(2);
    rst_n = 1'b1;
    u0 = upd_cnt;
    tick(6);
    check({tag, "_valid_early"}, valid, 0);
    check({tag, "_a_early"}, a_out, 0);
    tick(1);
    check({tag, "_a"}, a_out, 2);
    check({tag, "_b"}, b_out, 1);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_upd"}, upd, 1);
    check({tag, "_busy"}, busy, 0);
    tick(1);
    check({tag, "_upd_fall"}, upd, 0);
    tick(4);
    check({tag, "_upd_pulses"}, upd_cnt - u0, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int u0, b0, n;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    tick(3);

    // Reset release with A=2, B=1.
    reset_capture("s1");

    // A 2->3 with valid already high.
    set_ab(2'b11, 2'b01);
    u0 = upd_cnt;
    tick(6);
    check("s2_a_hold", a_out, 2);
    tick(1);
    check("s2_a", a_out, 3);
    check("s2_upd", upd, 1);
    check("s2_b", b_out, 1);
    tick(4);
    check("s2_upd_pulses", upd_cnt - u0, 1);

    // Bounce 3->0->3->0 every 2 cycles, then hold 0.
    u0 = upd_cnt;
    set_ab(2'b00, 2'b01); tick(2);
    set_ab(2'b11, 2'b01); tick(2);
    set_ab(2'b00, 2'b01);
    tick(6);
    check("s3_a_hold", a_out, 3);
    check("s3_no_upd", upd_cnt - u0, 0);
    tick(1);
    check("s3_a", a_out, 0);
    check("s3_upd", upd, 1);
    tick(4);

    // Glitch A 1->2 for two cycles, back to 1.
    set_ab(2'b01, 2'b01);
    tick(10);
    check("s4_a_pre", a_out, 1);
    u0 = upd_cnt;
    b0 = busy_cnt;
    set_ab(2'b10, 2'b01); tick(2);
    set_ab(2'b01, 2'b01); tick(12);
    check("s4_a", a_out, 1);
    check("s4_no_upd", upd_cnt - u0, 0);
    check("s4_busy_seen", busy_cnt > b0, 1);
    check("s4_busy_end", busy, 0);

    // A and B change on the same edge.
    set_ab(2'b00, 2'b00);
    tick(10);
    u0 = upd_cnt;
    set_ab(2'b11, 2'b10);
    tick(6);
    check("s5_a_hold", a_out, 0);
    check("s5_b_hold", b_out, 0);
    tick(1);
    check("s5_a", a_out, 3);
    check("s5_b", b_out, 2);
    check("s5_upd", upd, 1);
    tick(4);
    check("s5_upd_pulses", upd_cnt - u0, 1);

    // Reset while A is SETTLING with its counter at 2.
    set_ab(2'b01, 2'b10);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("s6_a", a_out, 0);
    check("s6_b", b_out, 0);
    check("s6_valid", valid, 0);
    check("s6_upd", upd, 0);
    check("s6_busy", busy, 1);
    reset_capture("s6");

`ifdef SW_ACTIVE_LOW_EN
    // Physical pins: A all pressed (low), B all released (high).
    sw_a = 2'b00;
    sw_b = 2'b11;
    tick(10);
    check("s7_a", a_out, 3);
    check("s7_b", b_out, 0);
`endif

    // Random holds, from bounce-length up to well past the debounce window.
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom_range(0, 3));
      rb = W'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: set_ab(ra, b_out);
        1: set_ab(a_out, rb);
        default: set_ab(ra, rb);
      endcase
      n = $urandom_range(1, 2 * (D + 3));
      tick(n);
      if (i == 30) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    end
    tick(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
